// File: rtl/fptd_razor_pkg.sv
// Shared types and defaults for the FPTD razor error-handshake controller.
// The optional per-stage sticky error log is enabled by defining RAZOR_ERR_LOG_EN.
package fptd_razor_pkg;

  localparam int NUM_STAGES_DEF = 8;
  localparam int ITER_W_DEF     = 6;
  localparam int CNT_W_DEF      = 16;
  localparam int MAX_CONSEC_DEF = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    REPLAY = 3'd3,
    DONE   = 3'd4,
    ABORT  = 3'd5
  } razor_state_t;

  // Two half-iterations per full iteration; a request of zero iterations runs one.
  function automatic int unsigned half_iter_target(input int unsigned iter);
    return (iter == 0) ? 2 : 2 * iter;
  endfunction

endpackage

// File: rtl/razor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module razor_sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Clear,
  input  logic         Enable,
  output logic [W-1:0] Count
);

  logic [W-1:0] count_reg;

  // Count enabled events, never wrapping past all-ones.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count_reg <= '0;
    end else if (Clear) begin
      count_reg <= '0;
    end else if (Enable && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign Count = count_reg;

endmodule

// File: rtl/fptd_razor_ctrl.sv
// FPTD razor controller: drives the Enable phase and nClear strobe of the pipe stages,
// replays a phase whenever any stage flags a razor error, counts half-iterations to the
// frame target and keeps a saturating replay count for voltage/clock tuning.
// Define RAZOR_ERR_LOG_EN to add the per-stage sticky error log output Err_sticky.
module fptd_razor_ctrl
  import fptd_razor_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ITER_W     = ITER_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CONSEC = MAX_CONSEC_DEF
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic [ITER_W-1:0]     Iter_max,
  input  logic [NUM_STAGES-1:0] Error_current,
  output logic                  Enable,
  output logic                  nClear,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fail,
  output logic [CNT_W-1:0]      Error_count
`ifdef RAZOR_ERR_LOG_EN
  ,
  output logic [NUM_STAGES-1:0] Err_sticky
`endif
);

  // Half-iteration counter is one bit wider than Iter_max so 2*Iter_max fits.
  localparam int HW = ITER_W + 1;
  // Consecutive counter can reach MAX_CONSEC+2 before the abort is taken.
  localparam int CW = $clog2(MAX_CONSEC + 3) + 1;
  localparam logic [CW-1:0] CONSEC_LIMIT = CW'(MAX_CONSEC);

  razor_state_t state_reg, state_next;
  logic [HW-1:0] half_reg, half_next, half_inc;
  logic [HW-1:0] target_reg, target_next;
  logic [CW-1:0] consec_reg, consec_next;
  logic          enable_reg, enable_next;
  logic          nclear_reg, busy_reg, done_reg, fail_reg;
  logic          err_any, err_event;

  assign err_any  = |Error_current;
  assign half_inc = half_reg + 1'b1;

  // Next-state, half-iteration and consecutive-replay bookkeeping.
  always_comb begin
    state_next  = state_reg;
    half_next   = half_reg;
    target_next = target_reg;
    consec_next = consec_reg;
    err_event   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next  = CLEAR;
          target_next = HW'(half_iter_target(32'(Iter_max)));
        end
      end
      CLEAR: begin
        state_next  = RUN;
        half_next   = '0;
        consec_next = '0;
      end
      RUN: begin
        if (err_any) begin
          // Error takes priority over completion: the phase is replayed first.
          err_event   = 1'b1;
          consec_next = consec_reg + 1'b1;
          state_next  = REPLAY;
        end else if (enable_reg) begin
          half_next   = half_inc;
          consec_next = '0;
          if (half_inc == target_reg) state_next = DONE;
        end
      end
      REPLAY: begin
        if (err_any) begin
          err_event   = 1'b1;
          consec_next = consec_reg + 1'b1;
          state_next  = (consec_next > CONSEC_LIMIT) ? ABORT : REPLAY;
        end else if (consec_reg > CONSEC_LIMIT) begin
          state_next = ABORT;
        end else begin
          // A clean replay of a capture phase completes that half-iteration.
          state_next = RUN;
          if (enable_reg) begin
            half_next   = half_inc;
            consec_next = '0;
            if (half_inc == target_reg) state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Phase generation: toggle in RUN, hold across REPLAY, low elsewhere.
  always_comb begin
    enable_next = 1'b0;
    case (state_next)
      RUN:     enable_next = (state_reg == CLEAR) ? 1'b1 : ~enable_reg;
      REPLAY:  enable_next = enable_reg;
      default: enable_next = 1'b0;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg  <= IDLE;
      half_reg   <= '0;
      target_reg <= '0;
      consec_reg <= '0;
    end else begin
      state_reg  <= state_next;
      half_reg   <= half_next;
      target_reg <= target_next;
      consec_reg <= consec_next;
    end
  end

  // Registered outputs decoded from the upcoming state so they align with it.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      enable_reg <= 1'b0;
      nclear_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      fail_reg   <= 1'b0;
    end else begin
      enable_reg <= enable_next;
      nclear_reg <= !((state_next == CLEAR) || (state_next == ABORT));
      busy_reg   <= (state_next == CLEAR) || (state_next == RUN) || (state_next == REPLAY);
      done_reg   <= (state_next == DONE);
      fail_reg   <= (state_next == ABORT);
    end
  end

  razor_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .Clock (Clock),
    .nReset(nReset),
    .Clear (1'b0),
    .Enable(err_event),
    .Count (Error_count)
  );

  assign Enable = enable_reg;
  assign nClear = nclear_reg;
  assign Busy   = busy_reg;
  assign Done   = done_reg;
  assign Fail   = fail_reg;

`ifdef RAZOR_ERR_LOG_EN
  logic [NUM_STAGES-1:0] sticky_reg;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sticky
    // Per-stage error flag, cleared as a frame starts, accumulating while the frame runs.
    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        sticky_reg[gi] <= 1'b0;
      end else if (state_next == CLEAR) begin
        sticky_reg[gi] <= 1'b0;
      end else if ((state_reg == RUN) || (state_reg == REPLAY)) begin
        sticky_reg[gi] <= sticky_reg[gi] | Error_current[gi];
      end
    end
  end

  assign Err_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_fptd_razor_ctrl.sv
// Scoreboard bench for fptd_razor_ctrl: each frame pushes its expected Enable phases and
// its expected ending (Done/Fail, latency from CLEAR, Error_count) before Start is driven;
// a negedge monitor pops and compares as the DUT produces them.
// Define RAZOR_ERR_LOG_EN to also exercise Err_sticky.
module tb_fptd_razor_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clock = 1'b0;
  logic             nReset = 1'b0;
  logic             Start = 1'b0;
  logic [5:0]       Iter_max = 6'd0;
  logic [7:0]       Error_current = 8'h00;
  logic             Enable, nClear, Busy, Done, Fail;
  logic [CNT_W-1:0] Error_count;
`ifdef RAZOR_ERR_LOG_EN
  logic [7:0]       Err_sticky;
`endif

  int vectors = 0;
  int miscompares = 0;
  int frame_cyc = 0;
  int model_errs = 0;

  typedef struct {
    string tag;
    bit    fail;
    int    lat;
    int    errs;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  logic       en_q[$];
  frame_exp_t mon_e;

  fptd_razor_ctrl #(
    .NUM_STAGES(8),
    .ITER_W    (6),
    .CNT_W     (CNT_W),
    .MAX_CONSEC(3)
  ) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .Start        (Start),
    .Iter_max     (Iter_max),
    .Error_current(Error_current),
    .Enable       (Enable),
    .nClear       (nClear),
    .Busy         (Busy),
    .Done         (Done),
    .Fail         (Fail),
    .Error_count  (Error_count)
`ifdef RAZOR_ERR_LOG_EN
    ,
    .Err_sticky   (Err_sticky)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: consumes expected Enable phases and frame endings.
  always @(negedge Clock) begin
    if (!nClear && Busy) begin
      frame_cyc = 0;
`ifdef RAZOR_ERR_LOG_EN
      check_eq("sticky_clear", 32'(Err_sticky), 32'h0);
`endif
    end else begin
      frame_cyc++;
    end
    if (Busy && nClear && en_q.size() > 0)
      check_eq("enable", 32'(Enable), 32'(en_q.pop_front()));
    if (Done || Fail) begin
      if (frame_q.size() == 0) begin
        check_eq("unexpected_end", 32'({Done, Fail}), 32'h0);
      end else begin
        mon_e = frame_q.pop_front();
        $display("frame %s: done=%0b fail=%0b lat=%0d err_count=%0d", mon_e.tag, Done, Fail,
                 frame_cyc, Error_count);
        check_eq({mon_e.tag, "_fail"}, 32'(Fail), 32'(mon_e.fail));
        check_eq({mon_e.tag, "_done"}, 32'(Done), 32'(!mon_e.fail));
        check_eq({mon_e.tag, "_latency"}, 32'(frame_cyc), 32'(mon_e.lat));
        check_eq({mon_e.tag, "_nclear"}, 32'(nClear), 32'(!mon_e.fail));
        check_eq({mon_e.tag, "_busy"}, 32'(Busy), 32'h0);
        check_eq({mon_e.tag, "_enable_low"}, 32'(Enable), 32'h0);
        check_eq({mon_e.tag, "_err_count"}, 32'(Error_count), 32'(mon_e.errs));
      end
    end
  end

  // Run one frame. Error_current = v1 on RUN-relative cycle c1 (from c1 onward if hold),
  // v2 on cycle c2. en_bits[i] is the expected Enable on cycle i+1 after CLEAR.
  task automatic run_frame(input string tag, input int iter,
                           input int c1, input logic [7:0] v1,
                           input int c2, input logic [7:0] v2, input bit hold,
                           input bit exp_fail, input int exp_lat, input int n_err,
                           input logic [15:0] en_bits, input int en_len, input bit poke);
    frame_exp_t e;
    bit seen_end = 1'b0;
    bit finished = 1'b0;
    model_errs = (model_errs + n_err > CNT_MAX) ? CNT_MAX : model_errs + n_err;
    for (int i = 0; i < en_len; i++) en_q.push_back(en_bits[i]);
    e.tag  = tag;
    e.fail = exp_fail;
    e.lat  = exp_lat;
    e.errs = model_errs;
    frame_q.push_back(e);
    @(posedge Clock); #1;
    Start    = 1'b1;
    Iter_max = 6'(iter);
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int k = 1; k <= 60 && !finished; k++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      if (seen_end) begin
        finished = 1'b1;
      end else if (Done || Fail) begin
        seen_end      = 1'b1;
        Error_current = 8'h00;
        if (poke) begin
          Start    = 1'b1;
          Iter_max = 6'd7;
        end
      end else begin
        Error_current = (k == c1 || (hold && k > c1)) ? v1 : (k == c2) ? v2 : 8'h00;
        if (poke && k == 2) begin
          Start    = 1'b1;
          Iter_max = 6'd7;
        end
      end
    end
    Start         = 1'b0;
    Error_current = 8'h00;
    check_eq({tag, "_ended"}, 32'(finished), 32'h1);
    if (poke) check_eq({tag, "_start_ignored"}, 32'(Busy), 32'h0);
    check_eq({tag, "_enq_drained"}, 32'(en_q.size()), 32'h0);
    check_eq({tag, "_frameq_drained"}, 32'(frame_q.size()), 32'h0);
    en_q.delete();
    frame_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_enable"}, 32'(Enable), 32'h0);
    check_eq({tag, "_nclear"}, 32'(nClear), 32'h1);
    check_eq({tag, "_busy"}, 32'(Busy), 32'h0);
    check_eq({tag, "_done"}, 32'(Done), 32'h0);
    check_eq({tag, "_fail"}, 32'(Fail), 32'h0);
    check_eq({tag, "_err_count"}, 32'(Error_count), 32'h0);
`ifdef RAZOR_ERR_LOG_EN
    check_eq({tag, "_sticky"}, 32'(Err_sticky), 32'h0);
`endif
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    nReset = 1'b1;
    repeat (2) @(posedge Clock);

    //        tag           it c1 v1     c2 v2     hd fl lat n  en_bits  len poke
    run_frame("clean_it2",   2, 0, 8'h00, 0, 8'h00, 0, 0, 8, 0, 16'h0055, 7, 0);
    run_frame("err_cap",     1, 1, 8'h04, 0, 8'h00, 0, 0, 5, 1, 16'h000B, 4, 0);
    run_frame("err_idle",    1, 2, 8'h80, 0, 8'h00, 0, 0, 5, 1, 16'h0009, 4, 0);
    run_frame("err_last",    1, 3, 8'h02, 0, 8'h00, 0, 0, 5, 1, 16'h000D, 4, 0);
    run_frame("iter_zero",   0, 0, 8'h00, 0, 8'h00, 0, 0, 4, 0, 16'h0005, 3, 0);
    run_frame("abort",       1, 1, 8'hFF, 0, 8'h00, 1, 1, 5, 4, 16'h000F, 4, 0);
    run_frame("start_poke",  2, 0, 8'h00, 0, 8'h00, 0, 0, 8, 0, 16'h0055, 7, 1);
`ifdef RAZOR_ERR_LOG_EN
    run_frame("sticky",      1, 1, 8'h01, 3, 8'h20, 0, 0, 6, 2, 16'h0013, 5, 0);
    check_eq("sticky_value", 32'(Err_sticky), 32'h21);
`endif

    // Asynchronous reset in the middle of a frame; no ending is expected.
    @(posedge Clock); #1;
    Start    = 1'b1;
    Iter_max = 6'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #2 nReset = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    model_errs = 0;
    @(negedge Clock);
    nReset = 1'b1;
    repeat (2) @(posedge Clock);
    run_frame("post_reset",  1, 0, 8'h00, 0, 8'h00, 0, 0, 4, 0, 16'h0005, 3, 0);

    // Twenty isolated errors drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++)
      run_frame("sat",       1, 1, 8'h10, 0, 8'h00, 0, 0, 5, 1, 16'h000B, 4, 0);
    check_eq("err_count_saturated", 32'(Error_count), 32'(model_errs));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
